// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative M-extension multiply/divide unit:
//   - funct3_e : funct3 encodings of the eight M-extension ops
//   - state_e  : sequencer states
//   - count_w  : width of the iteration down-counter for a given XLEN
// No ports (package).
// -----------------------------------------------------------------------------
package muldiv_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // COUNT_W: the counter must hold the value XLEN itself, hence the extra bit.
  function automatic int count_w(input int xlen);
    return $clog2(xlen) + 1;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// -----------------------------------------------------------------------------
// muldiv_if
// Request/response bundle between the execute stage and muldiv_seq.
//   start, flush, funct3, a, b : requester -> unit
//   ready, done, y             : unit -> requester
// Modports: master (execute stage), slave (muldiv_seq).
// -----------------------------------------------------------------------------
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            ready;
  logic            done;
  logic [XLEN-1:0] y;

  modport master (
    output start, flush, funct3, a, b,
    input  ready, done, y
  );

  modport slave (
    input  start, flush, funct3, a, b,
    output ready, done, y
  );
endinterface

// File: rtl/muldiv_negate.sv
// -----------------------------------------------------------------------------
// muldiv_negate
// Conditional two's-complement: q = neg ? -d : d.
// Used for operand magnitudes at accept and for result sign fixup.
//   d   : XLEN-bit input word
//   neg : negate when 1
//   q   : XLEN-bit result
// -----------------------------------------------------------------------------
module muldiv_negate #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] d,
  input  logic            neg,
  output logic [XLEN-1:0] q
);
  assign q = neg ? (~d + {{(XLEN-1){1'b0}}, 1'b1}) : d;
endmodule

// File: rtl/mux2.sv
// -----------------------------------------------------------------------------
// mux2
// Generic two-input word multiplexer.
//   sel : 0 selects d0, 1 selects d1
//   d0, d1 : W-bit data inputs
//   y   : W-bit output
// -----------------------------------------------------------------------------
module mux2 #(
  parameter int W = 32
) (
  input  logic         sel,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  output logic [W-1:0] y
);
  assign y = sel ? d1 : d0;
endmodule

// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq
// Iterative RV32M/RV64M multiply/divide unit, one bit per cycle.
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : muldiv_if.slave (start/flush/funct3/a/b in, ready/done/y out)
// Normal ops take XLEN CALC cycles plus FIX and DONE; divide by zero and
// signed overflow skip CALC. All arithmetic runs on magnitudes, signs are
// reapplied in FIX.
// -----------------------------------------------------------------------------
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic    clk,
  input  logic    rst_n,
  muldiv_if.slave bus
);

  localparam int              CW       = count_w(XLEN);
  localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ZERO_W   = {XLEN{1'b0}};

  state_e            state_r;
  logic [2:0]        op_r;
  logic [XLEN-1:0]   mag_a_r, mag_b_r;
  logic              neg_q_r, neg_r_r, special_r;
  logic [CW-1:0]     cnt_r;
  // mul: {high, low} product shift register; div: low half is dividend/quotient
  logic [2*XLEN-1:0] acc_r;
  logic [XLEN:0]     rem_r;
  logic              ready_r, done_r;
  logic [XLEN-1:0]   y_r;

  logic              a_signed_s, b_signed_s, sign_a_s, sign_b_s, div0_s, ovf_s;
  logic [XLEN-1:0]   abs_a_s, abs_b_s;
  logic [XLEN:0]     mul_sum_s;
  logic [2*XLEN-1:0] mul_next_s;
  logic [XLEN+1:0]   div_shift_s, div_diff_s;
  logic              div_ok_s;
  logic [XLEN:0]     div_rem_s;
  logic [XLEN-1:0]   div_word_s, result_s;
  logic [2*XLEN-1:0] fix_src_s, fixed_s;
  logic              fix_neg_s, hi_sel_s;

  assign bus.ready = ready_r;
  assign bus.done  = done_r;
  assign bus.y     = y_r;

  // Accept-time decode: operand signedness, sign flags and divide special cases
  always_comb begin
    a_signed_s = 1'b0;
    b_signed_s = 1'b0;
    case (bus.funct3)
      MULH, DIV, REM: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b1;
      end
      MULHSU:  a_signed_s = 1'b1;
      default: a_signed_s = 1'b0;
    endcase
    sign_a_s = a_signed_s & bus.a[XLEN-1];
    sign_b_s = b_signed_s & bus.b[XLEN-1];
    div0_s   = bus.funct3[2] & (bus.b == ZERO_W);
    ovf_s    = ((bus.funct3 == DIV) || (bus.funct3 == REM)) &&
               (bus.a == MOST_NEG) && (bus.b == ALL_ONES);
  end

  muldiv_negate #(.XLEN(XLEN)) u_abs_a (.d(bus.a), .neg(sign_a_s), .q(abs_a_s));
  muldiv_negate #(.XLEN(XLEN)) u_abs_b (.d(bus.b), .neg(sign_b_s), .q(abs_b_s));

  // One iteration step: shift-add multiply and restoring divide
  always_comb begin
    mul_sum_s = {1'b0, acc_r[2*XLEN-1:XLEN]} + {1'b0, mag_a_r};
    if (acc_r[0]) begin
      mul_next_s = {mul_sum_s, acc_r[XLEN-1:1]};
    end else begin
      mul_next_s = {1'b0, acc_r[2*XLEN-1:1]};
    end
    // Remainder stays below the divisor, so the top bit of the difference is the borrow
    div_shift_s = {rem_r, acc_r[XLEN-1]};
    div_diff_s  = div_shift_s - {2'b00, mag_b_r};
    div_ok_s    = ~div_diff_s[XLEN+1];
    if (div_ok_s) begin
      div_rem_s = div_diff_s[XLEN:0];
    end else begin
      div_rem_s = div_shift_s[XLEN:0];
    end
  end

  mux2 #(.W(XLEN)) u_div_sel (
    .sel(op_r[1]), .d0(acc_r[XLEN-1:0]), .d1(rem_r[XLEN-1:0]), .y(div_word_s)
  );

  // Result fixup: choose source word and whether it needs negating
  always_comb begin
    if (op_r[2]) begin
      fix_src_s = {ZERO_W, div_word_s};
    end else begin
      fix_src_s = acc_r;
    end
    if (special_r) begin
      fix_neg_s = 1'b0;
    end else if (op_r[2] && op_r[1]) begin
      fix_neg_s = neg_r_r;
    end else begin
      fix_neg_s = neg_q_r;
    end
    hi_sel_s = ~op_r[2] & (op_r[1:0] != 2'b00);
  end

  muldiv_negate #(.XLEN(2*XLEN)) u_fix (.d(fix_src_s), .neg(fix_neg_s), .q(fixed_s));

  mux2 #(.W(XLEN)) u_word_sel (
    .sel(hi_sel_s), .d0(fixed_s[XLEN-1:0]), .d1(fixed_s[2*XLEN-1:XLEN]), .y(result_s)
  );

  // Sequencer with registered handshake outputs and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      op_r      <= 3'b000;
      mag_a_r   <= ZERO_W;
      mag_b_r   <= ZERO_W;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      special_r <= 1'b0;
      cnt_r     <= {CW{1'b0}};
      acc_r     <= {(2*XLEN){1'b0}};
      rem_r     <= {(XLEN+1){1'b0}};
      ready_r   <= 1'b1;
      done_r    <= 1'b0;
      y_r       <= ZERO_W;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            op_r      <= bus.funct3;
            mag_a_r   <= abs_a_s;
            mag_b_r   <= abs_b_s;
            neg_q_r   <= sign_a_s ^ sign_b_s;
            neg_r_r   <= sign_a_s;
            special_r <= div0_s | ovf_s;
            cnt_r     <= CNT_INIT;
            ready_r   <= 1'b0;
            if (div0_s) begin
              acc_r   <= {ZERO_W, ALL_ONES};
              rem_r   <= {1'b0, bus.a};
              state_r <= FIX;
            end else if (ovf_s) begin
              acc_r   <= {ZERO_W, bus.a};
              rem_r   <= {(XLEN+1){1'b0}};
              state_r <= FIX;
            end else begin
              acc_r   <= {ZERO_W, (bus.funct3[2] ? abs_a_s : abs_b_s)};
              rem_r   <= {(XLEN+1){1'b0}};
              state_r <= CALC;
            end
          end else begin
            ready_r <= 1'b1;
          end
        end
        CALC: begin
          if (bus.flush) begin
            state_r <= IDLE;
            ready_r <= 1'b1;
          end else begin
            if (op_r[2]) begin
              rem_r <= div_rem_s;
              acc_r <= {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-2:0], div_ok_s};
            end else begin
              acc_r <= mul_next_s;
            end
            cnt_r <= cnt_r - CNT_ONE;
            if (cnt_r == CNT_LAST) begin
              state_r <= FIX;
            end
          end
        end
        FIX: begin
          if (bus.flush) begin
            state_r <= IDLE;
            ready_r <= 1'b1;
          end else begin
            y_r     <= result_s;
            done_r  <= 1'b1;
            state_r <= DONE;
          end
        end
        DONE: begin
          state_r <= IDLE;
          ready_r <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// -----------------------------------------------------------------------------
// tb_muldiv_seq
// Self-checking bench for muldiv_seq (XLEN=32). Expected results come from a
// plain-arithmetic reference of the RISC-V M-extension rules.
// -----------------------------------------------------------------------------
module tb_muldiv_seq;
  localparam int XLEN = 32;
  localparam int LAT_NORMAL  = XLEN + 2;
  localparam int LAT_SPECIAL = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   done_count = 0;
  logic [31:0] last_y = 32'h0;

  muldiv_if #(.XLEN(XLEN)) bus ();
  muldiv_seq #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Count completed done cycles (sampled before the edge updates outputs)
  always @(posedge clk) if (bus.done === 1'b1) done_count++;

  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    int qa, qb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    qa = $signed(a);
    qb = $signed(b);
    case (f3)
      3'b000: begin p = ua * ub; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * longint'(ub); return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: if (b == 32'd0) return 32'hFFFFFFFF;
              else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
              else return 32'(qa / qb);
      3'b101: if (b == 32'd0) return 32'hFFFFFFFF; else return a / b;
      3'b110: if (b == 32'd0) return a;
              else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
              else return 32'(qa % qb);
      3'b111: if (b == 32'd0) return a; else return a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b);
    if (f3[2] && (b == 32'd0 ||
        ((f3 == 3'b100 || f3 == 3'b110) && a == 32'h80000000 && b == 32'hFFFFFFFF)))
      return LAT_SPECIAL;
    return LAT_NORMAL;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0: return 32'h00000000;
      1: return 32'h00000001;
      2: return 32'h80000000;
      3: return 32'hFFFFFFFF;
      4: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issue one op and wait for done; lat counts cycles after the accept cycle
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] y_o, output int lat, output int busy_hi);
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = f3; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.funct3 = 3'($urandom);
    lat = -1; busy_hi = 0; y_o = 32'h0;
    for (int k = 1; k <= 100; k++) begin
      if (bus.done === 1'b1) begin
        lat = k; y_o = bus.y;
        break;
      end
      if (bus.ready !== 1'b0) busy_hi++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = 3'b000; bus.a = 32'h0; bus.b = 32'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.ready); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.y !== 32'h0) begin errors++; $display("FAIL reset_y got=%h exp=0", bus.y); end
  endtask

  typedef struct {
    logic [2:0] f3; logic [31:0] a; logic [31:0] b; logic [31:0] y; int lat;
  } vec_t;

  task automatic test_directed;
    vec_t v [14];
    logic [31:0] yo; int lat, busy;
    v = '{
      '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34},
      '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34},
      '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34},
      '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34},
      '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34},
      '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34},
      '{3'b101, 32'd100,      32'd7,        32'd14,       34},
      '{3'b111, 32'd100,      32'd7,        32'd2,        34},
      '{3'b101, 32'h12345678, 32'd0,        32'hFFFFFFFF, 2},
      '{3'b111, 32'h12345678, 32'd0,        32'h12345678, 2},
      '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2},
      '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2},
      '{3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 2},
      '{3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 2}
    };
    foreach (v[i]) begin
      run_op(v[i].f3, v[i].a, v[i].b, yo, lat, busy);
      checks++; if (yo !== v[i].y) begin errors++; $display("FAIL directed_y[%0d] got=%h exp=%h", i, yo, v[i].y); end
      checks++; if (lat != v[i].lat) begin errors++; $display("FAIL directed_lat[%0d] got=%0d exp=%0d", i, lat, v[i].lat); end
      checks++; if (busy != 0) begin errors++; $display("FAIL directed_ready_low[%0d] ready-high cycles=%0d exp=0", i, busy); end
      last_y = v[i].y;
    end
  endtask

  task automatic test_random;
    logic [2:0] f3; logic [31:0] a, b, yo, ye; int lat, busy;
    for (int n = 0; n < 60; n++) begin
      f3 = 3'($urandom); a = pick(); b = pick();
      ye = ref_op(f3, a, b);
      run_op(f3, a, b, yo, lat, busy);
      checks++; if (yo !== ye) begin errors++; $display("FAIL random_y f3=%0d a=%h b=%h got=%h exp=%h", f3, a, b, yo, ye); end
      checks++; if (lat != ref_lat(f3, a, b)) begin errors++; $display("FAIL random_lat f3=%0d a=%h b=%h got=%0d exp=%0d", f3, a, b, lat, ref_lat(f3, a, b)); end
      last_y = ye;
    end
  endtask

  task automatic test_flush;
    int dones, rdy_bad; logic [31:0] yo; int lat, busy;
    dones = 0; rdy_bad = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'b000; bus.a = 32'd1234; bus.b = 32'd5678;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k < 10; k++) begin
      if (bus.done === 1'b1) dones++;
      @(negedge clk);
    end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL flush_ready got=%b exp=1", bus.ready); end
    for (int k = 0; k < 40; k++) begin
      if (bus.done === 1'b1) dones++;
      if (bus.ready !== 1'b1) rdy_bad++;
      @(negedge clk);
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL flush_no_done got=%0d exp=0", dones); end
    checks++; if (rdy_bad != 0) begin errors++; $display("FAIL flush_idle_ready bad=%0d exp=0", rdy_bad); end
    checks++; if (bus.y !== last_y) begin errors++; $display("FAIL flush_y_hold got=%h exp=%h", bus.y, last_y); end
    run_op(3'b101, 32'd9, 32'd3, yo, lat, busy);
    checks++; if (yo !== 32'd3) begin errors++; $display("FAIL after_flush_y got=%h exp=3", yo); end
    checks++; if (lat != LAT_NORMAL) begin errors++; $display("FAIL after_flush_lat got=%0d exp=%0d", lat, LAT_NORMAL); end
    last_y = 32'd3;
    // start while busy must be ignored
    dones = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'b101; bus.a = 32'd100; bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      if (k == 5) begin bus.start = 1'b1; bus.funct3 = 3'b000; bus.a = 32'd3; bus.b = 32'd5; end
      else bus.start = 1'b0;
      if (bus.done === 1'b1) dones++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    checks++; if (dones != 1) begin errors++; $display("FAIL busy_start_dones got=%0d exp=1", dones); end
    checks++; if (bus.y !== 32'd14) begin errors++; $display("FAIL busy_start_y got=%h exp=%h", bus.y, 32'd14); end
    last_y = 32'd14;
    // flush together with start in IDLE drops the request
    dones = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = 3'b000; bus.a = 32'd2; bus.b = 32'd2;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL flush_start_ready got=%b exp=1", bus.ready); end
    for (int k = 0; k < 40; k++) begin
      if (bus.done === 1'b1) dones++;
      @(negedge clk);
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL flush_start_dones got=%0d exp=0", dones); end
    checks++; if (bus.y !== last_y) begin errors++; $display("FAIL flush_start_y got=%h exp=%h", bus.y, last_y); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'b001; bus.a = 32'hDEADBEEF; bus.b = 32'h01234567;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0; bus.start = 1'b1; bus.flush = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; bus.start = 1'b0; bus.flush = 1'b0;
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got=%b exp=1", bus.ready); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midreset_done got=%b exp=0", bus.done); end
    checks++; if (bus.y !== 32'h0) begin errors++; $display("FAIL midreset_y got=%h exp=0", bus.y); end
    last_y = 32'h0;
  endtask

  task automatic test_back_to_back;
    int c0; logic [2:0] f3; logic [31:0] a, b, yo, ye; int lat, busy;
    c0 = done_count;
    for (int n = 0; n < 6; n++) begin
      f3 = 3'($urandom); a = pick(); b = pick();
      ye = ref_op(f3, a, b);
      run_op(f3, a, b, yo, lat, busy);
      checks++; if (yo !== ye) begin errors++; $display("FAIL b2b_y[%0d] got=%h exp=%h", n, yo, ye); end
      last_y = ye;
      if (n == 2) begin
        // start raised in the done cycle itself must be ignored
        bus.start = 1'b1; bus.funct3 = 3'b000; bus.a = 32'd2; bus.b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL start_in_done_ready got=%b exp=1", bus.ready); end
      end
    end
    repeat (40) @(negedge clk);
    checks++; if (done_count - c0 != 6) begin errors++; $display("FAIL b2b_done_pulses got=%0d exp=6", done_count - c0); end
    checks++; if (bus.y !== last_y) begin errors++; $display("FAIL b2b_y_hold got=%h exp=%h", bus.y, last_y); end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_flush;
    test_reset_mid;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
